// File: rtl/pipe_ctrl.sv
// Pipelined MIPS control unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control bundles,
// load-use / branch / jump hazard handling and a BREAK drain-to-halt FSM.
module pipe_ctrl #(
  parameter int unsigned ALUOP_W   = 5,
  parameter int unsigned EXTOP_W   = 2,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        id_instr,
  input  logic               id_valid,
  input  logic               ex_zero,
  input  logic               dmem_busy,
  output logic               stall_if,
  output logic               flush_if_id,
  output logic [1:0]         pc_sel,
  output logic [EXTOP_W-1:0] id_extop,
  output logic [ALUOP_W-1:0] ex_aluctrl,
  output logic               ex_alusrc,
  output logic               ex_alushift,
  output logic               ex_regdst,
  output logic               ex_branch,
  output logic               ex_nbranch,
  output logic [4:0]         ex_rt,
  output logic               mem_memr,
  output logic               mem_memw,
  output logic               wb_regw,
  output logic               wb_mem2r,
  output logic               halt,
  output logic               illegal
);
  localparam int unsigned CNT_W = 4;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_ADDI = 6'h08, OP_ORI = 6'h0d, OP_LUI = 6'h0f,
                         OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_BREAK = 6'h0d,
                         FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25,
                         FN_XOR = 6'h26, FN_SLT = 6'h2a;

  localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(1),  ALU_ADD = ALUOP_W'(3),
                                 ALU_SUB = ALUOP_W'(4),  ALU_SLT = ALUOP_W'(10),
                                 ALU_XOR = ALUOP_W'(12), ALU_OR  = ALUOP_W'(13),
                                 ALU_AND = ALUOP_W'(14), ALU_SLL = ALUOP_W'(15),
                                 ALU_SRL = ALUOP_W'(16), ALU_SRA = ALUOP_W'(17);
  localparam logic [EXTOP_W-1:0] EXT_ZERO = EXTOP_W'(0), EXT_SIGN = EXTOP_W'(1),
                                 EXT_LUI  = EXTOP_W'(2);

  typedef struct packed {
    logic [ALUOP_W-1:0] aluctrl;
    logic               alusrc;
    logic               alushift;
    logic               regdst;
    logic               branch;
    logic               nbranch;
    logic [4:0]         rt;
    logic               memr;
    logic               memw;
    logic               regw;
    logic               mem2r;
  } idex_t;

  typedef struct packed {
    logic memr;
    logic memw;
    logic regw;
    logic mem2r;
  } exmem_t;

  typedef struct packed {
    logic regw;
    logic mem2r;
  } memwb_t;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;
  assign op = id_instr[31:26];
  assign rs = id_instr[25:21];
  assign rt = id_instr[20:16];
  assign rd = id_instr[15:11];
  assign fn = id_instr[5:0];

  logic unused_shamt;
  assign unused_shamt = ^id_instr[10:6];

  idex_t              dec;
  logic [EXTOP_W-1:0] dec_ext;
  logic               dec_ill, is_j, is_brk, uses_rt;

  // Instruction decode; unknown encodings collapse to a bubble
  always_comb begin
    dec     = '0;
    dec.rt  = rt;
    dec_ext = EXT_ZERO;
    dec_ill = 1'b0;
    is_j    = 1'b0;
    is_brk  = 1'b0;
    uses_rt = 1'b0;
    case (op)
      OP_R: begin
        uses_rt    = 1'b1;
        dec.regdst = 1'b1;
        dec.regw   = 1'b1;
        case (fn)
          FN_ADDU:  dec.aluctrl = ALU_ADD;
          FN_SUBU:  dec.aluctrl = ALU_SUB;
          FN_SLT:   dec.aluctrl = ALU_SLT;
          FN_AND:   dec.aluctrl = ALU_AND;
          FN_OR:    dec.aluctrl = ALU_OR;
          FN_XOR:   dec.aluctrl = ALU_XOR;
          FN_SLL: begin
            dec.aluctrl  = ALU_SLL;
            dec.alushift = 1'b1;
            dec.regw     = (rd != 5'd0);
          end
          FN_SRL: begin
            dec.aluctrl  = ALU_SRL;
            dec.alushift = 1'b1;
          end
          FN_SRA: begin
            dec.aluctrl  = ALU_SRA;
            dec.alushift = 1'b1;
          end
          FN_BREAK: is_brk  = 1'b1;
          default:  dec_ill = 1'b1;
        endcase
      end
      OP_ORI:  begin dec.aluctrl = ALU_OR;  dec.alusrc = 1'b1; dec.regw = 1'b1; end
      OP_LUI:  begin dec.aluctrl = ALU_LUI; dec.alusrc = 1'b1; dec.regw = 1'b1; dec_ext = EXT_LUI; end
      OP_ADDI: begin dec.aluctrl = ALU_ADD; dec.alusrc = 1'b1; dec.regw = 1'b1; dec_ext = EXT_SIGN; end
      OP_LW: begin
        dec.aluctrl = ALU_ADD;
        dec.alusrc  = 1'b1;
        dec.memr    = 1'b1;
        dec.regw    = 1'b1;
        dec.mem2r   = 1'b1;
        dec_ext     = EXT_SIGN;
      end
      OP_SW: begin
        dec.aluctrl = ALU_ADD;
        dec.alusrc  = 1'b1;
        dec.memw    = 1'b1;
        dec_ext     = EXT_SIGN;
        uses_rt     = 1'b1;
      end
      OP_BEQ: begin dec.aluctrl = ALU_SUB; dec.branch  = 1'b1; dec_ext = EXT_SIGN; uses_rt = 1'b1; end
      OP_BNE: begin dec.aluctrl = ALU_SUB; dec.nbranch = 1'b1; dec_ext = EXT_SIGN; uses_rt = 1'b1; end
      OP_J:    is_j    = 1'b1;
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill || is_brk || is_j) dec = '0;
  end

  assign id_extop = dec_ext;

  idex_t            id_ex_q, id_ex_d;
  exmem_t           ex_mem_q, ex_mem_d;
  memwb_t           mem_wb_q, mem_wb_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_q, halt_d, illegal_q, illegal_d;
  logic             taken, load_use;

  assign taken    = (id_ex_q.branch & ex_zero) | (id_ex_q.nbranch & ~ex_zero);
  assign load_use = id_valid && id_ex_q.memr && (id_ex_q.rt != 5'd0) &&
                    ((id_ex_q.rt == rs) || (uses_rt && (id_ex_q.rt == rt)));

  // Hazard priority and next-state; ID/EX defaults to a bubble
  always_comb begin
    stall_if       = 1'b0;
    flush_if_id    = 1'b0;
    pc_sel         = 2'd0;
    id_ex_d        = '0;
    ex_mem_d.memr  = id_ex_q.memr;
    ex_mem_d.memw  = id_ex_q.memw;
    ex_mem_d.regw  = id_ex_q.regw;
    ex_mem_d.mem2r = id_ex_q.mem2r;
    mem_wb_d.regw  = ex_mem_q.regw;
    mem_wb_d.mem2r = ex_mem_q.mem2r;
    state_d        = state_q;
    cnt_d          = cnt_q;
    halt_d         = halt_q;
    illegal_d      = 1'b0;
    if (dmem_busy) begin
      stall_if = 1'b1;
    end else begin
      case (state_q)
        S_RUN: begin
          if (taken) begin
            pc_sel      = 2'd1;
            flush_if_id = 1'b1;
          end else if (load_use) begin
            stall_if = 1'b1;
          end else if (id_valid && is_j) begin
            pc_sel      = 2'd2;
            flush_if_id = 1'b1;
          end else if (id_valid && is_brk) begin
            stall_if = 1'b1;
            state_d  = S_DRAIN;
            cnt_d    = CNT_W'(DRAIN_CYC);
          end else if (id_valid) begin
            id_ex_d   = dec;
            illegal_d = dec_ill;
          end
        end
        S_DRAIN: begin
          stall_if = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_HALT;
            halt_d  = 1'b1;
          end
        end
        default: stall_if = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q   <= '0;
      ex_mem_q  <= '0;
      mem_wb_q  <= '0;
      state_q   <= S_RUN;
      cnt_q     <= '0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
      if (!dmem_busy) begin
        id_ex_q  <= id_ex_d;
        ex_mem_q <= ex_mem_d;
        mem_wb_q <= mem_wb_d;
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        halt_q   <= halt_d;
      end
    end
  end

  assign ex_aluctrl  = id_ex_q.aluctrl;
  assign ex_alusrc   = id_ex_q.alusrc;
  assign ex_alushift = id_ex_q.alushift;
  assign ex_regdst   = id_ex_q.regdst;
  assign ex_branch   = id_ex_q.branch;
  assign ex_nbranch  = id_ex_q.nbranch;
  assign ex_rt       = id_ex_q.rt;
  assign mem_memr    = ex_mem_q.memr;
  assign mem_memw    = ex_mem_q.memw;
  assign wb_regw     = mem_wb_q.regw;
  assign wb_mem2r    = mem_wb_q.mem2r;
  assign halt        = halt_q;
  assign illegal     = illegal_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: table of per-cycle vectors with a stage-delay scoreboard,
// plus hand sequences for BREAK drain, reset during drain and stalls during drain.
module tb_pipe_ctrl;
  localparam int unsigned ALUOP_W   = 5;
  localparam int unsigned EXTOP_W   = 2;
  localparam int unsigned DRAIN_CYC = 3;

  localparam logic [4:0] A_LUI = 5'd1, A_ADD = 5'd3, A_SUB = 5'd4, A_SLT = 5'd10,
                         A_XOR = 5'd12, A_OR = 5'd13, A_AND = 5'd14, A_SLL = 5'd15,
                         A_SRL = 5'd16, A_SRA = 5'd17;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] id_instr;
  logic id_valid, ex_zero, dmem_busy;
  logic stall_if, flush_if_id;
  logic [1:0] pc_sel;
  logic [EXTOP_W-1:0] id_extop;
  logic [ALUOP_W-1:0] ex_aluctrl;
  logic ex_alusrc, ex_alushift, ex_regdst, ex_branch, ex_nbranch;
  logic [4:0] ex_rt;
  logic mem_memr, mem_memw, wb_regw, wb_mem2r, halt, illegal;

  pipe_ctrl #(.ALUOP_W(ALUOP_W), .EXTOP_W(EXTOP_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
    .ex_zero(ex_zero), .dmem_busy(dmem_busy), .stall_if(stall_if),
    .flush_if_id(flush_if_id), .pc_sel(pc_sel), .id_extop(id_extop),
    .ex_aluctrl(ex_aluctrl), .ex_alusrc(ex_alusrc), .ex_alushift(ex_alushift),
    .ex_regdst(ex_regdst), .ex_branch(ex_branch), .ex_nbranch(ex_nbranch),
    .ex_rt(ex_rt), .mem_memr(mem_memr), .mem_memw(mem_memw), .wb_regw(wb_regw),
    .wb_mem2r(wb_mem2r), .halt(halt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] alu;
    logic src, sh, rd, br, nbr;
    logic [4:0] rt;
    logic mr, mw, rw, m2r;
  } bnd_t;

  typedef struct {
    logic [31:0] instr;
    logic v, z, bz;
    logic st, fl;
    logic [1:0] pc, ext;
    bnd_t en;
    logic il;
  } vec_t;

  vec_t vecs[$];
  bnd_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic bnd_t mk(input logic [4:0] alu, input logic src, sh, rd, br, nbr,
                              input logic [4:0] rt, input logic mr, mw, rw, m2r);
    bnd_t b;
    b = {alu, src, sh, rd, br, nbr, rt, mr, mw, rw, m2r};
    return b;
  endfunction

  function automatic bnd_t e_r(input logic [4:0] alu, input logic [4:0] rt, input logic rw, sh);
    return mk(alu, 1'b0, sh, 1'b1, 1'b0, 1'b0, rt, 1'b0, 1'b0, rw, 1'b0);
  endfunction
  function automatic bnd_t e_lw(input logic [4:0] rt);
    return mk(A_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rt, 1'b1, 1'b0, 1'b1, 1'b1);
  endfunction
  function automatic bnd_t e_sw(input logic [4:0] rt);
    return mk(A_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rt, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic bnd_t e_br(input logic [4:0] rt, input logic ne);
    return mk(A_SUB, 1'b0, 1'b0, 1'b0, ~ne, ne, rt, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic bnd_t e_imm(input logic [4:0] alu, input logic [4:0] rt);
    return mk(alu, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rt, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  task automatic add(input logic [31:0] instr, input logic v, z, bz, st, fl,
                     input logic [1:0] pc, ext, input bnd_t en, input logic il);
    vec_t t;
    t.instr = instr; t.v = v; t.z = z; t.bz = bz; t.st = st; t.fl = fl;
    t.pc = pc; t.ext = ext; t.en = en; t.il = il;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic [31:0] instr, input logic v, z, bz);
    id_instr = instr; id_valid = v; ex_zero = z; dmem_busy = bz;
  endtask

  task automatic do_reset();
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    repeat (3) sb.push_back('0);
  endtask

  task automatic chk_pipe(input string tag);
    bnd_t e;
    e = sb[2];
    chk({tag, ".ex"}, 32'({ex_aluctrl, ex_alusrc, ex_alushift, ex_regdst, ex_branch, ex_nbranch, ex_rt}),
        32'({e.alu, e.src, e.sh, e.rd, e.br, e.nbr, e.rt}));
    chk({tag, ".mem"}, 32'({mem_memr, mem_memw}), 32'({sb[1].mr, sb[1].mw}));
    chk({tag, ".wb"}, 32'({wb_regw, wb_mem2r}), 32'({sb[0].rw, sb[0].m2r}));
  endtask

  // One vector = one clock: combinational checks mid-cycle, registered checks after the edge
  task automatic apply(input vec_t t, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    drive(t.instr, t.v, t.z, t.bz);
    #3;
    chk({tag, ".stall_if"}, 32'(stall_if), 32'(t.st));
    chk({tag, ".flush_if_id"}, 32'(flush_if_id), 32'(t.fl));
    chk({tag, ".pc_sel"}, 32'(pc_sel), 32'(t.pc));
    chk({tag, ".id_extop"}, 32'(id_extop), 32'(t.ext));
    @(posedge clk);
    if (!t.bz) begin
      sb.push_back(t.en);
      void'(sb.pop_front());
    end
    #1;
    chk_pipe(tag);
    chk({tag, ".illegal"}, 32'(illegal), 32'(t.il));
    chk({tag, ".halt"}, 32'(halt), 32'h0);
  endtask

  initial begin
    logic [31:0] addu, brk, jmp, bad_op, beq, bne;
    bnd_t bb;
    bb     = '0;
    addu   = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
    brk    = {6'h00, 20'h0, 6'h0d};
    jmp    = {6'h02, 26'h10};
    bad_op = {6'h3f, 26'h0};
    beq    = enc_i(6'h04, 5'd1, 5'd2, 16'h4);
    bne    = enc_i(6'h05, 5'd1, 5'd2, 16'h4);

    // decode and plain pipeline flow
    add(addu, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, e_r(A_ADD, 5'd2, 1'b1, 1'b0), 1'b0);
    add(enc_i(6'h23, 5'd4, 5'd5, 16'h0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, e_lw(5'd5), 1'b0);
    add(enc_i(6'h2b, 5'd6, 5'd7, 16'h0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, e_sw(5'd7), 1'b0);
    repeat (3) add(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, bb, 1'b0);
    // load-use: rs match, rs match with ORI, $0 producer, SW rt match, ORI rt-only (no stall)
    add(enc_i(6'h23, 5'd1, 5'd2, 16'h0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, e_lw(5'd2), 1'b0);
    add(enc_r(5'd2, 5'd4, 5'd3, 5'd0, 6'h21), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, bb, 1'b0);
    add(enc_r(5'd2, 5'd4, 5'd3, 5'd0, 6'h21), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, e_r(A_ADD, 5'd4, 1'b1, 1'b0), 1'b0);
    add(enc_i(6'h23, 5'd1, 5'd2, 16'h0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, e_lw(5'd2), 1'b0);
    add(enc_i(6'h0d, 5'd2, 5'd2, 16'h5), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, bb, 1'b0);
    add(enc_i(6'h0d, 5'd2, 5'd2, 16'h5), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, e_imm(A_OR, 5'd2), 1'b0);
    add(enc_i(6'h23, 5'd1, 5'd0, 16'h0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, e_lw(5'd0), 1'b0);
    add(enc_r(5'd0, 5'd0, 5'd3, 5'd0, 6'h21), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, e_r(A_ADD, 5'd0, 1'b1, 1'b0), 1'b0);
    add(enc_i(6'h23, 5'd1, 5'd6, 16'h0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, e_lw(5'd6), 1'b0);
    add(enc_i(6'h2b, 5'd7, 5'd6, 16'h0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, bb, 1'b0);
    add(enc_i(6'h2b, 5'd7, 5'd6, 16'h0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, e_sw(5'd6), 1'b0);
    add(enc_i(6'h23, 5'd1, 5'd8, 16'h0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, e_lw(5'd8), 1'b0);
    add(enc_i(6'h0d, 5'd9, 5'd8, 16'h1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, e_imm(A_OR, 5'd8), 1'b0);
    // branches and jump
    add(beq, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, e_br(5'd2, 1'b0), 1'b0);
    add(addu, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, bb, 1'b0);
    add(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, bb, 1'b0);
    add(bne, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, e_br(5'd2, 1'b1), 1'b0);
    add(addu, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, e_r(A_ADD, 5'd2, 1'b1, 1'b0), 1'b0);
    add(bne, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, e_br(5'd2, 1'b1), 1'b0);
    add(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, bb, 1'b0);
    add(jmp, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, bb, 1'b0);
    add(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, bb, 1'b0);
    add(beq, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, e_br(5'd2, 1'b0), 1'b0);
    add(addu, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, e_r(A_ADD, 5'd2, 1'b1, 1'b0), 1'b0);
    // taken branch beats J and BREAK in ID; FSM stays in RUN
    add(beq, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, e_br(5'd2, 1'b0), 1'b0);
    add(jmp, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, bb, 1'b0);
    add(beq, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, e_br(5'd2, 1'b0), 1'b0);
    add(brk, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, bb, 1'b0);
    add(addu, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, e_r(A_ADD, 5'd2, 1'b1, 1'b0), 1'b0);
    // dmem_busy freeze, including over a taken branch
    add(enc_i(6'h23, 5'd4, 5'd5, 16'h0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, e_lw(5'd5), 1'b0);
    add(enc_i(6'h2b, 5'd6, 5'd7, 16'h0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, e_sw(5'd7), 1'b0);
    repeat (3) add(addu, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, bb, 1'b0);
    add(addu, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, e_r(A_ADD, 5'd2, 1'b1, 1'b0), 1'b0);
    add(beq, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, e_br(5'd2, 1'b0), 1'b0);
    add(jmp, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, bb, 1'b0);
    add(jmp, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, bb, 1'b0);
    // illegal opcode / funct; invalid slot never flags
    add(bad_op, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, bb, 1'b1);
    add(addu, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, e_r(A_ADD, 5'd2, 1'b1, 1'b0), 1'b0);
    add(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h3f), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, bb, 1'b1);
    add(bad_op, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, bb, 1'b0);
    // remaining decode values
    add(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h23), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, e_r(A_SUB, 5'd2, 1'b1, 1'b0), 1'b0);
    add(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h2a), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, e_r(A_SLT, 5'd2, 1'b1, 1'b0), 1'b0);
    add(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h24), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, e_r(A_AND, 5'd2, 1'b1, 1'b0), 1'b0);
    add(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h25), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, e_r(A_OR, 5'd2, 1'b1, 1'b0), 1'b0);
    add(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h26), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, e_r(A_XOR, 5'd2, 1'b1, 1'b0), 1'b0);
    add(enc_r(5'd0, 5'd2, 5'd3, 5'd4, 6'h00), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, e_r(A_SLL, 5'd2, 1'b1, 1'b1), 1'b0);
    add(enc_r(5'd0, 5'd2, 5'd3, 5'd4, 6'h02), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, e_r(A_SRL, 5'd2, 1'b1, 1'b1), 1'b0);
    add(enc_r(5'd0, 5'd2, 5'd3, 5'd4, 6'h03), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, e_r(A_SRA, 5'd2, 1'b1, 1'b1), 1'b0);
    add(enc_r(5'd0, 5'd2, 5'd0, 5'd1, 6'h00), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, e_r(A_SLL, 5'd2, 1'b0, 1'b1), 1'b0);
    add(enc_i(6'h0f, 5'd0, 5'd4, 16'h1234), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, e_imm(A_LUI, 5'd4), 1'b0);
    add(enc_i(6'h08, 5'd1, 5'd5, 16'hffff), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, e_imm(A_ADD, 5'd5), 1'b0);
    repeat (3) add(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, bb, 1'b0);

    do_reset();
    #3;
    chk("reset.stall_if", 32'(stall_if), 32'h0);
    chk("reset.flush_if_id", 32'(flush_if_id), 32'h0);
    chk("reset.pc_sel", 32'(pc_sel), 32'h0);
    chk("reset.halt", 32'(halt), 32'h0);
    chk("reset.illegal", 32'(illegal), 32'h0);
    chk_pipe("reset");
    @(posedge clk); #1;

    foreach (vecs[i]) apply(vecs[i], i);

    // BREAK: halt rises DRAIN_CYC+1 edges after acceptance and stays
    do_reset();
    drive(brk, 1'b1, 1'b0, 1'b0);
    #3 chk("brk.accept_stall", 32'(stall_if), 32'h1);
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      chk($sformatf("brk.halt_e%0d", k), 32'(halt), 32'(k >= int'(DRAIN_CYC) + 1));
      if (k >= 4) chk($sformatf("brk.wb_e%0d", k), 32'({wb_regw, ex_regdst, mem_memr}), 32'h0);
      drive(addu, 1'b1, 1'b0, 1'b0);
      #3 chk($sformatf("brk.stall_e%0d", k), 32'(stall_if), 32'h1);
    end

    // async reset in DRAIN returns to RUN; halt never rises
    do_reset();
    drive(brk, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(addu, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("rstdrain.stall_pre", 32'(stall_if), 32'h1);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1 chk("rstdrain.stall_in_rst", 32'(stall_if), 32'h0);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rstdrain.halt_e%0d", k), 32'(halt), 32'h0);
    end
    drive(addu, 1'b1, 1'b0, 1'b0);
    #3 chk("rstdrain.run_stall", 32'(stall_if), 32'h0);
    @(posedge clk); #1;
    chk("rstdrain.run_ex", 32'({ex_aluctrl, ex_regdst}), 32'({A_ADD, 1'b1}));

    // dmem_busy during DRAIN pauses the countdown
    do_reset();
    drive(brk, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("brkbusy.halt_e%0d", k), 32'(halt), 32'(k >= 6));
      drive(32'h0, 1'b0, 1'b0, (k == 1) || (k == 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
